aes_encrypt_iter: RTL and testbench

//  Iterative AES-128/192/256 encryption core; the forward-direction counterpart of the decrypt datapath.

---
 rtl/aes_encrypt_iter_pkg.sv | 84 ++++++++
 rtl/aes_encrypt_iter_round.sv | 57 +++++
 rtl/aes_encrypt_iter_seg.sv | 31 +++
 rtl/aes_encrypt_iter.sv | 130 +++++++++++++
 tb/tb_aes_encrypt_iter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES definitions for the iterative encryption core.
//   - block / key-schedule widths and round counts per key size
//   - key-size select encodings on the 2-bit switch input
//   - FSM state type
//   - S-box, xtime and seven-segment helper functions
package aes_encrypt_iter_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KS_W  = 1920;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // switch encodings; any value with bit 1 set selects AES-256
    localparam logic [1:0] SW_AES128 = 2'b00;
    localparam logic [1:0] SW_AES192 = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nr_from_switch(input logic [1:0] sw);
        logic [3:0] nr;
        if (sw[1])
            nr = NR_256;
        else if (sw == SW_AES192)
            nr = NR_192;
        else
            nr = NR_128;
        return nr;
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}; non-decimal codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7f;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// One combinational AES encryption round:
//   SubBytes -> ShiftRows -> MixColumns (skipped when last=1) -> AddRoundKey.
// Ports:
//   st_in  [127:0] state entering the round (byte 0 in bits 127:120)
//   rk     [127:0] round key
//   last           1 = final round, MixColumns bypassed
//   st_out [127:0] state leaving the round
// Byte k of the block holds state row k%4, column k/4 (column-major).
module aes_enc_round
    import aes_encrypt_iter_pkg::*;
(
    input  logic [AES_BLK_W-1:0] st_in,
    input  logic [AES_BLK_W-1:0] rk,
    input  logic                 last,
    output logic [AES_BLK_W-1:0] st_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(st_in[AES_BLK_W-1-8*k -: 8]);
        end
    end

    // Row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c])   ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                      ^ sr[4*c+2]        ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c]          ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                      ^ sr[4*c+2]        ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c]          ^ sr[4*c+1]        ^ xtime(sr[4*c+2])
                      ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c])   ^ sr[4*c]          ^ sr[4*c+1]
                      ^ sr[4*c+2]        ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        st_out = '0;
        for (int k = 0; k < 16; k++) begin
            st_out[AES_BLK_W-1-8*k -: 8] = (last ? sr[k] : mc[k]) ^ rk[AES_BLK_W-1-8*k -: 8];
        end
    end

endmodule

// File: rtl/aes_encrypt_iter_seg.sv
// Decimal seven-segment display of an 8-bit value (0..255).
// Ports:
//   value [7:0] byte to display
//   h1    [6:0] hundreds digit
//   h2    [6:0] tens digit
//   h3    [6:0] ones digit
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
module SevenSegment
    import aes_encrypt_iter_pkg::*;
(
    input  logic [7:0] value,
    output logic [6:0] h1,
    output logic [6:0] h2,
    output logic [6:0] h3
);

    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;

    always_comb begin
        hund = 4'(value / 8'd100);
        tens = 4'((value / 8'd10) % 8'd10);
        ones = 4'(value % 8'd10);
    end

    assign h1 = seg7(hund);
    assign h2 = seg7(tens);
    assign h3 = seg7(ones);

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          request, only sampled in IDLE
//   switch  [1:0]  key size: 00=AES-128, 01=AES-192, 1x=AES-256
//   in      [127:0] plaintext, captured on the accepting edge
//   key_e   [1919:0] forward key schedule, round key i at [1919-128*i -: 128];
//                  not registered, must stay stable while busy
//   out     [127:0] ciphertext, held until the next done
//   busy           high from accept until done
//   done           one-cycle pulse with new out
//   h1,h2,h3 [6:0] seven-segment digits of out[7:0]
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; round counter parked at 0
// ST_ROUND | full rounds 1..nr-1, one per edge, result back into st_q
// ST_FINAL | last round (no MixColumns) written to out, done pulsed
module aes_encrypt_iter
    import aes_encrypt_iter_pkg::*;
#(
    parameter int BLK_W = AES_BLK_W,
    parameter int KS_W  = AES_KS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       switch,
    input  logic [BLK_W-1:0] in,
    input  logic [KS_W-1:0]  key_e,
    output logic [BLK_W-1:0] out,
    output logic             busy,
    output logic             done,
    output logic [6:0]       h1,
    output logic [6:0]       h2,
    output logic [6:0]       h3
);

    aes_state_e       state_q, state_d;
    logic [BLK_W-1:0] st_q;
    logic [3:0]       round_q;
    logic [3:0]       nr_q;
    logic [BLK_W-1:0] rk_sel;
    logic [BLK_W-1:0] round_out;
    logic             last;
    logic             accept;
    logic             step;
    logic             finish;

    // round_q never exceeds nr_q (max 14), so the select stays inside key_e.
    assign rk_sel = key_e[KS_W-1 - BLK_W*int'(round_q) -: BLK_W];
    assign last   = (state_q == ST_FINAL);

    aes_enc_round u_round (
        .st_in  (st_q),
        .rk     (rk_sel),
        .last   (last),
        .st_out (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                step = 1'b1;
                if (round_q == nr_q - 4'd1)
                    state_d = ST_FINAL;
            end
            ST_FINAL: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= '0;
            out     <= '0;
            round_q <= 4'd0;
            nr_q    <= NR_128;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                nr_q    <= nr_from_switch(switch);
                st_q    <= in ^ key_e[KS_W-1 -: BLK_W];
                round_q <= 4'd1;
                busy    <= 1'b1;
            end
            if (step) begin
                st_q    <= round_out;
                round_q <= round_q + 4'd1;
            end
            if (finish) begin
                out     <= round_out;
                done    <= 1'b1;
                busy    <= 1'b0;
                round_q <= 4'd0;
            end
        end
    end

    SevenSegment u_seg (
        .value (out[7:0]),
        .h1    (h1),
        .h2    (h2),
        .h3    (h3)
    );

endmodule

// File: tb/tb_aes_encrypt_iter.sv
module tb_aes_encrypt_iter;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     switch;
    logic [127:0]   in;
    logic [1919:0]  key_e;
    logic [127:0]   out;
    logic           busy;
    logic           done;
    logic [6:0]     h1, h2, h3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_m [256];
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_encrypt_iter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .switch (switch),
        .in     (in),
        .key_e  (key_e),
        .out    (out),
        .busy   (busy),
        .done   (done),
        .h1     (h1),
        .h2     (h2),
        .h3     (h3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb_m[a] = s;
        end
    endtask

    function automatic int nr_of(input logic [1:0] sw);
        return sw[1] ? 14 : (sw[0] ? 12 : 10);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb_m[x[31:24]], sb_m[x[23:16]], sb_m[x[15:8]], sb_m[x[7:0]]};
    endfunction

    function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int            nk;
        nk = nr - 6;
        ks = '0;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 4*(nr+1); i++) ks[1919-32*i -: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [1919:0] ks, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ks[1919-8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb_m[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) t[i] = s[4*c+i];
                    for (int i = 0; i < 4; i++)
                        s[4*c+i] = gmul(8'h02, t[i]) ^ gmul(8'h03, t[(i+1)%4])
                                 ^ t[(i+2)%4] ^ t[(i+3)%4];
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[1919-128*r-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_seg(input string tag);
        int v;
        v = int'(out[7:0]);
        check({tag, "_h1"}, 128'(h1), 128'(seg_tab[v / 100]));
        check({tag, "_h2"}, 128'(h2), 128'(seg_tab[(v / 10) % 10]));
        check({tag, "_h3"}, 128'(h3), 128'(seg_tab[v % 10]));
    endtask

    // One block: accept, optional noise on switch/in and stray starts, then checks.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [255:0] key,
                             input logic [1:0] sw, input bit toggle, input bit extra,
                             input logic [127:0] exp);
        int nr, lat, nd;
        logic [127:0] ct_at_done;
        nr = nr_of(sw);
        key_e  = key_expand(key, nr);
        in     = pt;
        switch = sw;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nd = 0; ct_at_done = '0;
        check({tag, "_busy_acc"}, 128'(busy), 128'(1));
        for (int c = 1; c <= nr + 4; c++) begin
            in = {$urandom, $urandom, $urandom, $urandom};
            if (toggle) switch = 2'($urandom);
            start = extra && (c == 3 || c == 7);
            @(posedge clk); #1;
            if (c == nr - 1) check({tag, "_busy_mid"}, 128'(busy), 128'(1));
            if (done) begin
                nd++;
                if (nd == 1) begin
                    lat = c;
                    ct_at_done = out;
                end
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(nr));
        check({tag, "_ndone"}, 128'(nd), 128'(1));
        check({tag, "_ct"}, ct_at_done, exp);
        check({tag, "_ct_hold"}, out, exp);
        check({tag, "_busy_end"}, 128'(busy), 128'(0));
        check_seg(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0]  pt, exp;
        logic [255:0]  key;
        logic [1:0]    sw;
        logic [1919:0] ks1, ks2;
        int nd, t1, t2;

        build_sbox();
        rst = 1'b1; start = 1'b0; switch = 2'b00; in = '0; key_e = '0;
        #12;
        check("rst_out", out, 128'h0);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check_seg("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_block("c1", PT_FIPS, K128, 2'b00, 1'b0, 1'b0, CT128);
        run_block("c2", PT_FIPS, K192, 2'b01, 1'b1, 1'b0, CT192);
        run_block("c3_10", PT_FIPS, K256, 2'b10, 1'b0, 1'b0, CT256);
        run_block("c3_11", PT_FIPS, K256, 2'b11, 1'b0, 1'b0, CT256);
        run_block("c1_stray", PT_FIPS, K128, 2'b00, 1'b0, 1'b1, CT128);

        // Reset part-way through a C.1 block.
        key_e = key_expand(K128, 10); in = PT_FIPS; switch = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out", out, 128'h0);
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("midrst_nodone", 128'(nd), 128'(0));
        run_block("c1_after_rst", PT_FIPS, K128, 2'b00, 1'b0, 1'b0, CT128);

        // Back-to-back: start held high across a C.1 block then a C.2 block.
        ks1 = key_expand(K128, 10);
        ks2 = key_expand(K192, 12);
        key_e = ks1; in = PT_FIPS; switch = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        nd = 0; t1 = -1; t2 = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    t1 = c;
                    check("b2b_ct1", out, CT128);
                    check_seg("b2b1");
                    key_e = ks2; in = PT_FIPS; switch = 2'b01;
                end else if (nd == 2) begin
                    t2 = c;
                    check("b2b_ct2", out, CT192);
                    check_seg("b2b2");
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_ndone", 128'(nd), 128'(2));
        check("b2b_lat1", 128'(t1), 128'(10));
        // second accept on the edge after done, then 12 rounds
        check("b2b_gap", 128'(t2 - t1), 128'(13));

        // Randomized blocks against the model.
        for (int i = 0; i < 8; i++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            sw  = 2'($urandom_range(0, 3));
            exp = aes_model(pt, key_expand(key, nr_of(sw)), nr_of(sw));
            run_block($sformatf("rnd%0d", i), pt, key, sw,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
